// File: rtl/slope_detect_pkg.sv
// Shared types and defaults for the sliding-window slope detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slope_detect_pkg;

  // Event FSM: IDLE may fire an event, HOLD suppresses events for a sample budget
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH         = 16;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_POS_THRESHOLD = 10;
  localparam int DEF_NEG_THRESHOLD = 10;
  localparam int DEF_MIN_DELTA     = 0;
  localparam int DEF_HOLDOFF       = 32;

  // Score width; the window never scores more than DEPTH-1, so this always fits
  function automatic int score_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/slope_popcount.sv
// Population count of a DEPTH-bit compare vector.
// Latency: combinational.
// Backpressure: none; caller keeps at least one bit clear so the count fits score_width(DEPTH).
module slope_popcount
  import slope_detect_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic [DEPTH-1:0]                bits,
  output logic [score_width(DEPTH)-1:0]   count
);

  localparam int SW = score_width(DEPTH);

  // Ripple sum of set bits
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + SW'(bits[k]);
    end
  end

endmodule

// File: rtl/slope_detect_win.sv
// Sliding-window slope detector: oldest sample vs every newer one, with deadband, levels and held-off events.
// Latency: sample accepted at edge N -> scores after N+1 -> levels/events after N+2.
// Backpressure: none; i_valid may be high every clock, gaps freeze the window. SLOPE_DETECT_SIGNED_EN selects signed samples.
module slope_detect_win
  import slope_detect_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int POS_THRESHOLD = DEF_POS_THRESHOLD,
  parameter int NEG_THRESHOLD = DEF_NEG_THRESHOLD,
  parameter int MIN_DELTA     = DEF_MIN_DELTA,
  parameter int HOLDOFF       = DEF_HOLDOFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic [WIDTH-1:0]               i_in,
  output logic                           o_primed,
  output logic [score_width(DEPTH)-1:0]  o_score_pos,
  output logic [score_width(DEPTH)-1:0]  o_score_neg,
  output logic                           o_pos_slope,
  output logic                           o_neg_slope,
  output logic                           o_pos_event,
  output logic                           o_neg_event
);

  localparam int SW = score_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = $clog2(HOLDOFF + 2);

  // Compares run one bit wider than the samples so oldest +/- deadband cannot wrap
`ifdef SLOPE_DETECT_SIGNED_EN
  typedef logic signed [WIDTH:0] ext_t;
  function automatic ext_t extend(input logic [WIDTH-1:0] v);
    return ext_t'({v[WIDTH-1], v});
  endfunction
`else
  typedef logic [WIDTH:0] ext_t;
  function automatic ext_t extend(input logic [WIDTH-1:0] v);
    return {1'b0, v};
  endfunction
`endif

  localparam ext_t DELTA = ext_t'(MIN_DELTA);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    fill;
  ext_t             oldest;
  logic [DEPTH-1:0] bit_pos;
  logic [DEPTH-1:0] bit_neg;
  logic [SW-1:0]    cnt_pos;
  logic [SW-1:0]    cnt_neg;
  logic             pos_next;
  logic             neg_next;
  logic             pos_rise;
  logic             neg_rise;
  state_t           state;
  state_t           state_nxt;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_nxt;
  logic             ev_pos;
  logic             ev_neg;

  // Window shift register; mem[0] is the oldest sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (i_valid) begin
      for (int k = 1; k < DEPTH; k++) mem[k-1] <= mem[k];
      mem[DEPTH-1] <= i_in;
    end
  end

  // Accepted-sample counter, saturating once the window is full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else if (i_valid && (fill != CW'(DEPTH))) begin
      fill <= fill + CW'(1);
    end
  end

  assign o_primed = (fill == CW'(DEPTH));

  // Oldest-vs-newer compares; bit 0 (oldest vs itself) stays clear
  always_comb begin
    bit_pos = '0;
    bit_neg = '0;
    oldest  = extend(mem[0]);
    for (int k = 1; k < DEPTH; k++) begin
      bit_pos[k] = extend(mem[k]) > (oldest + DELTA);
      bit_neg[k] = (extend(mem[k]) + DELTA) < oldest;
    end
  end

  slope_popcount #(.DEPTH(DEPTH)) u_pop_pos (
    .bits  (bit_pos),
    .count (cnt_pos)
  );

  slope_popcount #(.DEPTH(DEPTH)) u_pop_neg (
    .bits  (bit_neg),
    .count (cnt_neg)
  );

  // Stage 1: scores re-registered every clock, held at zero until the window is full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_score_pos <= '0;
      o_score_neg <= '0;
    end else begin
      o_score_pos <= o_primed ? cnt_pos : '0;
      o_score_neg <= o_primed ? cnt_neg : '0;
    end
  end

  assign pos_next = int'(o_score_pos) > POS_THRESHOLD;
  assign neg_next = int'(o_score_neg) > NEG_THRESHOLD;
  assign pos_rise = pos_next && !o_pos_slope;
  assign neg_rise = neg_next && !o_neg_slope;

  // Stage 2: slope levels track the scores regardless of FSM state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_pos_slope <= 1'b0;
      o_neg_slope <= 1'b0;
    end else begin
      o_pos_slope <= pos_next;
      o_neg_slope <= neg_next;
    end
  end

  // Event FSM next state: positive wins a tie; rises seen in HOLD are discarded, not deferred
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    ev_pos    = 1'b0;
    ev_neg    = 1'b0;
    case (state)
      IDLE: begin
        if (pos_rise || neg_rise) begin
          ev_pos   = pos_rise;
          ev_neg   = !pos_rise;
          hold_nxt = HW'(HOLDOFF);
          if (HOLDOFF != 0) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (i_valid) begin
          hold_nxt = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
          if (hold_cnt <= HW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event FSM registers and one-clock event pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      o_pos_event <= 1'b0;
      o_neg_event <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      o_pos_event <= ev_pos;
      o_neg_event <= ev_neg;
    end
  end

endmodule

// File: tb/tb_slope_detect_win.sv
// Directed bench for slope_detect_win: three instances (default, deadband 3, 4-bit samples).
// Expectations are hand-derived from the sample tables below.
module tb_slope_detect_win;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] in_a  = '0;
  logic [15:0] in_b  = '0;
  logic [3:0]  in_c  = '0;

  logic       pa, ps_a, ns_a, pe_a, ne_a;
  logic [3:0] sp_a, sn_a;
  logic       pb, ps_b, ns_b, pe_b, ne_b;
  logic [3:0] sp_b, sn_b;
  logic       pc, ps_c, ns_c, pe_c, ne_c;
  logic [3:0] sp_c, sn_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slope_detect_win dut_a (
    .clk(clk), .reset(reset), .i_valid(valid), .i_in(in_a),
    .o_primed(pa), .o_score_pos(sp_a), .o_score_neg(sn_a),
    .o_pos_slope(ps_a), .o_neg_slope(ns_a), .o_pos_event(pe_a), .o_neg_event(ne_a)
  );

  slope_detect_win #(.MIN_DELTA(3)) dut_b (
    .clk(clk), .reset(reset), .i_valid(valid), .i_in(in_b),
    .o_primed(pb), .o_score_pos(sp_b), .o_score_neg(sn_b),
    .o_pos_slope(ps_b), .o_neg_slope(ns_b), .o_pos_event(pe_b), .o_neg_event(ne_b)
  );

  slope_detect_win #(.WIDTH(4)) dut_c (
    .clk(clk), .reset(reset), .i_valid(valid), .i_in(in_c),
    .o_primed(pc), .o_score_pos(sp_c), .o_score_neg(sn_c),
    .o_pos_slope(ps_c), .o_neg_slope(ns_c), .o_pos_event(pe_c), .o_neg_event(ne_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Up ramp 100..119, down ramp 118..78, flat 78, second down ramp from 77
  function automatic logic [15:0] seq_a(input int j);
    if (j <= 19)      return 16'(100 + j);
    else if (j <= 60) return 16'(138 - j);
    else if (j <= 80) return 16'd78;
    else              return 16'(158 - j);
  endfunction

  logic [15:0] noise [24] = '{100, 102, 99, 101, 100, 99, 102, 101, 100, 99, 101, 102,
                              100, 99, 101, 100, 102, 99, 101, 100, 99, 102, 101, 100};
  logic [15:0] bnd [16]   = '{100, 103, 103, 103, 104, 104, 104, 104,
                              97, 97, 96, 96, 96, 100, 100, 100};

  initial begin
    // Reset state
    #12;
    chk("rst_a", 32'({pa, sp_a, sn_a, ps_a, ns_a, pe_a, ne_a}), 32'd0);
    chk("rst_b", 32'({pb, sp_b, sn_b, ps_b, ns_b, pe_b, ne_b}), 32'd0);
    chk("rst_c", 32'({pc, sp_c, sn_c, ps_c, ns_c, pe_c, ne_c}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Priming, pos event at 17, holdoff masks neg level, neg event at 93 after expiry
    valid = 1'b1;
    for (int j = 0; j <= 100; j++) begin
      in_a = seq_a(j);
      tick();
      chk($sformatf("primed_%0d", j), 32'(pa), 32'(j >= 15));
      chk($sformatf("pos_ev_%0d", j), 32'(pe_a), 32'(j == 17));
      chk($sformatf("neg_ev_%0d", j), 32'(ne_a), 32'(j == 93));
      if (j == 14) chk("score_unprimed", 32'({sp_a, sn_a}), 32'd0);
      if (j == 16) begin
        chk("score_pos_full", 32'(sp_a), 32'd15);
        chk("score_neg_full", 32'(sn_a), 32'd0);
      end
      if (j == 17) chk("pos_level_17", 32'(ps_a), 32'd1);
      if (j == 40) begin
        chk("pos_level_40", 32'(ps_a), 32'd0);
        chk("neg_level_40", 32'(ns_a), 32'd1);
        chk("neg_score_40", 32'(sn_a), 32'd15);
      end
      if (j == 60) chk("neg_level_60", 32'(ns_a), 32'd1);
      if (j == 80) chk("neg_level_80", 32'(ns_a), 32'd0);
      if (j == 100) begin
        chk("neg_level_100", 32'(ns_a), 32'd1);
        chk("neg_score_100", 32'(sn_a), 32'd15);
      end
    end

    // Reset asserted mid-HOLD clears everything at once
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_hold", 32'({pa, sp_a, sn_a, ps_a, ns_a, pe_a, ne_a}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j <= 19; j++) begin
      in_a = seq_a(j);
      tick();
      chk($sformatf("re_primed_%0d", j), 32'(pa), 32'(j >= 15));
      chk($sformatf("re_pos_ev_%0d", j), 32'(pe_a), 32'(j == 17));
    end

    // Noise within a spread of 3 stays inside the deadband
    valid = 1'b0;
    pulse_reset();
    valid = 1'b1;
    for (int j = 0; j < 24; j++) begin
      in_b = noise[j];
      tick();
      chk($sformatf("noise_scores_%0d", j), 32'({sp_b, sn_b}), 32'd0);
      chk($sformatf("noise_events_%0d", j), 32'({pe_b, ne_b}), 32'd0);
    end
    chk("noise_primed", 32'(pb), 32'd1);

    // Deadband boundary: +/-3 ignored, +/-4 counted; i_valid gap holds the scores
    valid = 1'b0;
    pulse_reset();
    valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      in_b = bnd[j];
      tick();
    end
    valid = 1'b0;
    in_b  = 16'd0;
    tick();
    chk("bnd_score_pos", 32'(sp_b), 32'd4);
    chk("bnd_score_neg", 32'(sn_b), 32'd3);
    tick();
    chk("gap_score_pos", 32'(sp_b), 32'd4);
    chk("gap_score_neg", 32'(sn_b), 32'd3);
    chk("bnd_levels", 32'({ps_b, ns_b}), 32'd0);

    // 4-bit codes 8..15,0..7 (-8..7 as two's complement)
    pulse_reset();
    valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      in_c = 4'(j + 8);
      tick();
    end
    valid = 1'b0;
    tick();
`ifdef SLOPE_DETECT_SIGNED_EN
    chk("w4_score_pos", 32'(sp_c), 32'd15);
    chk("w4_score_neg", 32'(sn_c), 32'd0);
`else
    chk("w4_score_pos", 32'(sp_c), 32'd7);
    chk("w4_score_neg", 32'(sn_c), 32'd8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
